// File: rtl/mbist_mux_nrep_pkg.sv
// Shared helpers for the multi-spare MBIST memory mux.
package mbist_mux_nrep_pkg;

  localparam int MAX_REPAIR_CNT = 8;

  // Inclusive range check on zero-extended addresses.
  function automatic logic in_rng(input logic [15:0] a, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mbist_def.svh
// Repair table entry layout shared by the repair CAM.
// An entry is {valid, addr}; valid sits at the MSB so the serial repair
// chain order falls directly out of the packed layout.
`ifndef MBIST_DEF_SVH
`define MBIST_DEF_SVH
`define MBIST_ENTRY_T(AW) struct packed { logic valid; logic [(AW)-1:0] addr; }
`endif

// File: rtl/mbist_repair_cam.sv
// Repair CAM: table of {valid, addr} entries, two lookup ports with
// lowest-index priority, de-duplicating allocator fed by BIST errors,
// and a serial scan chain over the whole table.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr, shift, sdi, sdo  table clear, chain shift enable, chain in/out
//   err, err_addr         failing-address capture pulse
//   addr_a/addr_b         lookup addresses; hit_x/idx_x lookup results
//   fail                  sticky repair-capacity / spare-failure flag
//   cnt                   number of valid entries
module mbist_repair_cam
  import mbist_mux_nrep_pkg::*;
#(
  parameter int                 ADDR_WD      = 9,
  parameter int                 CNT          = 4,
  parameter logic [ADDR_WD-1:0] ADDR_START   = 9'h000,
  parameter logic [ADDR_WD-1:0] ADDR_END     = 9'h1F0,
  parameter logic [ADDR_WD-1:0] REPAIR_START = 9'h1F8,
  localparam int IW = (CNT > 1) ? $clog2(CNT) : 1,
  localparam int CW = $clog2(CNT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic               sdi,
  output logic               sdo,
  input  logic               err,
  input  logic [ADDR_WD-1:0] err_addr,
  input  logic [ADDR_WD-1:0] addr_a,
  input  logic [ADDR_WD-1:0] addr_b,
  output logic               hit_a,
  output logic [IW-1:0]      idx_a,
  output logic               hit_b,
  output logic [IW-1:0]      idx_b,
  output logic               fail,
  output logic [CW-1:0]      cnt
);

  `include "mbist_def.svh"
  typedef `MBIST_ENTRY_T(ADDR_WD) entry_t;

  localparam int EW = ADDR_WD + 1;

  entry_t [CNT-1:0]     tbl;
  logic   [CNT*EW-1:0]  chain;
  logic                 err_hit;
  logic                 free_ok;
  logic   [IW-1:0]      free_idx;
  logic                 err_spare;
  logic                 err_in_rng;

  assign chain = tbl;
  assign sdo   = chain[0];

  assign err_spare  = in_rng(16'(err_addr), 16'(REPAIR_START),
                             16'(REPAIR_START) + 16'(CNT - 1));
  assign err_in_rng = in_rng(16'(err_addr), 16'(ADDR_START), 16'(ADDR_END));

  // Descending loops so the lowest matching / free index is the last write.
  always_comb begin
    hit_a    = 1'b0;
    idx_a    = '0;
    hit_b    = 1'b0;
    idx_b    = '0;
    err_hit  = 1'b0;
    free_ok  = 1'b0;
    free_idx = '0;
    cnt      = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].addr == addr_a) begin
        hit_a = 1'b1;
        idx_a = IW'(i);
      end
      if (tbl[i].valid && tbl[i].addr == addr_b) begin
        hit_b = 1'b1;
        idx_b = IW'(i);
      end
      if (tbl[i].valid && tbl[i].addr == err_addr) err_hit = 1'b1;
      if (!tbl[i].valid) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
      cnt = cnt + CW'(tbl[i].valid);
    end
    // Only repairable addresses are ever remapped.
    if (!in_rng(16'(addr_a), 16'(ADDR_START), 16'(ADDR_END))) hit_a = 1'b0;
    if (!in_rng(16'(addr_b), 16'(ADDR_START), 16'(ADDR_END))) hit_b = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl  <= '0;
      fail <= 1'b0;
    end else if (clr) begin
      tbl  <= '0;
      fail <= 1'b0;
    end else if (shift) begin
      tbl <= {sdi, chain[CNT*EW-1:1]};
    end else if (err) begin
      if (err_hit) begin
        // already repaired
      end else if (err_spare) begin
        fail <= 1'b1;
      end else if (!err_in_rng) begin
        // not repairable, not a spare: ignore
      end else if (free_ok) begin
        tbl[free_idx].valid <= 1'b1;
        tbl[free_idx].addr  <= err_addr;
      end else begin
        fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbist_mux_nrep.sv
// MBIST / functional mux for a dual-port SRAM (read port A, write port B)
// with BIST_REPAIR_CNT spare rows. BIST or functional controls are muxed
// combinationally, then both port addresses are remapped onto spares via
// a shared repair CAM.
// Ports: clk/rst_n; BIST controls (bist_*); functional port A/B (func_*);
// memory port A/B (mem_*); repair status (bist_correct, bist_fail_repair,
// bist_repair_cnt) and repair scan chain (bist_shift, bist_sdi, bist_sdo).
module mbist_mux_nrep
  import mbist_mux_nrep_pkg::*;
#(
  parameter int                      BIST_ADDR_WD           = 9,
  parameter int                      BIST_DATA_WD           = 32,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START        = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END          = 9'h1F0,
  parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1F8,
  parameter int                      BIST_REPAIR_CNT        = 4,
  localparam int MW = BIST_DATA_WD / 8,
  localparam int CW = $clog2(BIST_REPAIR_CNT + 1),
  localparam int IW = (BIST_REPAIR_CNT > 1) ? $clog2(BIST_REPAIR_CNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_mode,
  input  logic                    bist_en,
  input  logic [BIST_ADDR_WD-1:0] bist_addr,
  input  logic [BIST_DATA_WD-1:0] bist_wdata,
  input  logic                    bist_wr,
  input  logic                    bist_rd,
  input  logic                    bist_error,
  input  logic [BIST_ADDR_WD-1:0] bist_error_addr,
  input  logic                    bist_repair_clr,
  input  logic                    bist_shift,
  input  logic                    bist_sdi,
  output logic                    bist_sdo,
  output logic                    bist_correct,
  output logic                    bist_fail_repair,
  output logic [CW-1:0]           bist_repair_cnt,
  input  logic                    func_cen_a,
  input  logic [BIST_ADDR_WD-1:0] func_addr_a,
  output logic [BIST_DATA_WD-1:0] func_dout_a,
  input  logic                    func_cen_b,
  input  logic                    func_web_b,
  input  logic [MW-1:0]           func_mask_b,
  input  logic [BIST_ADDR_WD-1:0] func_addr_b,
  input  logic [BIST_DATA_WD-1:0] func_din_b,
  output logic                    mem_cen_a,
  output logic [BIST_ADDR_WD-1:0] mem_addr_a,
  input  logic [BIST_DATA_WD-1:0] mem_dout_a,
  output logic                    mem_cen_b,
  output logic                    mem_web_b,
  output logic [MW-1:0]           mem_mask_b,
  output logic [BIST_ADDR_WD-1:0] mem_addr_b,
  output logic [BIST_DATA_WD-1:0] mem_din_b
);

  logic [BIST_ADDR_WD-1:0] pre_a, pre_b;
  logic                    hit_a, hit_b;
  logic [IW-1:0]           idx_a, idx_b;

  assign pre_a      = bist_en ? bist_addr : func_addr_a;
  assign pre_b      = bist_en ? bist_addr : func_addr_b;
  assign mem_cen_a  = bist_en ? !bist_rd  : func_cen_a;
  assign mem_cen_b  = bist_en ? !bist_wr  : func_cen_b;
  assign mem_web_b  = bist_en ? !bist_wr  : func_web_b;
  assign mem_mask_b = bist_en ? '1        : func_mask_b;
  assign mem_din_b  = bist_en ? bist_wdata : func_din_b;

  // In scan mode the write data is looped back so the read path is observable.
  assign func_dout_a = scan_mode ? mem_din_b : mem_dout_a;

  assign mem_addr_a = hit_a ? BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(idx_a) : pre_a;
  assign mem_addr_b = hit_b ? BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(idx_b) : pre_b;

  assign bist_correct = (bist_repair_cnt != '0) && !bist_fail_repair;

  mbist_repair_cam #(
    .ADDR_WD      (BIST_ADDR_WD),
    .CNT          (BIST_REPAIR_CNT),
    .ADDR_START   (BIST_ADDR_START),
    .ADDR_END     (BIST_ADDR_END),
    .REPAIR_START (BIST_REPAIR_ADDR_START)
  ) u_cam (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bist_repair_clr),
    .shift    (bist_shift),
    .sdi      (bist_sdi),
    .sdo      (bist_sdo),
    .err      (bist_error),
    .err_addr (bist_error_addr),
    .addr_a   (pre_a),
    .addr_b   (pre_b),
    .hit_a    (hit_a),
    .idx_a    (idx_a),
    .hit_b    (hit_b),
    .idx_b    (idx_b),
    .fail     (bist_fail_repair),
    .cnt      (bist_repair_cnt)
  );

endmodule

// File: tb/tb_mbist_mux_nrep.sv
module tb_mbist_mux_nrep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_mode = 1'b0;
  logic        bist_en = 1'b0;
  logic [8:0]  bist_addr = '0;
  logic [31:0] bist_wdata = '0;
  logic        bist_wr = 1'b0, bist_rd = 1'b0;
  logic        bist_error = 1'b0;
  logic [8:0]  bist_error_addr = '0;
  logic        bist_repair_clr = 1'b0, bist_shift = 1'b0, bist_sdi = 1'b0;
  logic        bist_sdo, bist_correct, bist_fail_repair;
  logic [2:0]  bist_repair_cnt;
  logic        func_cen_a = 1'b1;
  logic [8:0]  func_addr_a = '0;
  logic [31:0] func_dout_a;
  logic        func_cen_b = 1'b1, func_web_b = 1'b1;
  logic [3:0]  func_mask_b = '0;
  logic [8:0]  func_addr_b = '0;
  logic [31:0] func_din_b = '0;
  logic        mem_cen_a;
  logic [8:0]  mem_addr_a;
  logic [31:0] mem_dout_a = '0;
  logic        mem_cen_b, mem_web_b;
  logic [3:0]  mem_mask_b;
  logic [8:0]  mem_addr_b;
  logic [31:0] mem_din_b;

  int checks = 0;
  int errors = 0;

  mbist_mux_nrep dut (
    .clk(clk), .rst_n(rst_n), .scan_mode(scan_mode), .bist_en(bist_en),
    .bist_addr(bist_addr), .bist_wdata(bist_wdata), .bist_wr(bist_wr),
    .bist_rd(bist_rd), .bist_error(bist_error), .bist_error_addr(bist_error_addr),
    .bist_repair_clr(bist_repair_clr), .bist_shift(bist_shift), .bist_sdi(bist_sdi),
    .bist_sdo(bist_sdo), .bist_correct(bist_correct),
    .bist_fail_repair(bist_fail_repair), .bist_repair_cnt(bist_repair_cnt),
    .func_cen_a(func_cen_a), .func_addr_a(func_addr_a), .func_dout_a(func_dout_a),
    .func_cen_b(func_cen_b), .func_web_b(func_web_b), .func_mask_b(func_mask_b),
    .func_addr_b(func_addr_b), .func_din_b(func_din_b),
    .mem_cen_a(mem_cen_a), .mem_addr_a(mem_addr_a), .mem_dout_a(mem_dout_a),
    .mem_cen_b(mem_cen_b), .mem_web_b(mem_web_b), .mem_mask_b(mem_mask_b),
    .mem_addr_b(mem_addr_b), .mem_din_b(mem_din_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may be changed afterwards, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic err_pulse(input logic [8:0] a);
    bist_error      = 1'b1;
    bist_error_addr = a;
    tick();
    bist_error      = 1'b0;
  endtask

  logic [39:0] stream;
  logic [39:0] exp_chain;

  initial begin
    // Reset state
    bist_en   = 1'b1;
    bist_addr = 9'h055;
    bist_rd   = 1'b1;
    #12;
    chk("rst_cnt",   64'(bist_repair_cnt), 64'd0);
    chk("rst_corr",  64'(bist_correct), 64'd0);
    chk("rst_fail",  64'(bist_fail_repair), 64'd0);
    chk("rst_sdo",   64'(bist_sdo), 64'd0);
    chk("rst_addr_a", 64'(mem_addr_a), 64'h055);
    chk("rst_mask",  64'(mem_mask_b), 64'hF);
    chk("rst_cen_a", 64'(mem_cen_a), 64'd0);
    chk("rst_cen_b", 64'(mem_cen_b), 64'd1);
    rst_n = 1'b1;
    tick();

    // Dedup: 010, 020, 010 back to back
    err_pulse(9'h010);
    err_pulse(9'h020);
    err_pulse(9'h010);
    chk("dedup_cnt", 64'(bist_repair_cnt), 64'd2);
    bist_addr = 9'h020;
    #1;
    chk("remap_a_020", 64'(mem_addr_a), 64'h1F9);
    chk("remap_b_020", 64'(mem_addr_b), 64'h1F9);
    chk("corr_2", 64'(bist_correct), 64'd1);

    // Capture latency: same-cycle access sees old table
    bist_addr       = 9'h030;
    bist_error      = 1'b1;
    bist_error_addr = 9'h030;
    #1;
    chk("lat_before", 64'(mem_addr_a), 64'h030);
    tick();
    bist_error = 1'b0;
    chk("lat_after", 64'(mem_addr_a), 64'h1FA);
    chk("cnt_3", 64'(bist_repair_cnt), 64'd3);

    // Functional path through the remap
    bist_en     = 1'b0;
    func_addr_a = 9'h020;
    func_addr_b = 9'h010;
    func_mask_b = 4'h3;
    func_web_b  = 1'b0;
    #1;
    chk("func_a", 64'(mem_addr_a), 64'h1F9);
    chk("func_b", 64'(mem_addr_b), 64'h1F8);
    chk("func_mask", 64'(mem_mask_b), 64'h3);
    chk("func_web", 64'(mem_web_b), 64'd0);
    func_addr_a = 9'h1F4;
    #1;
    chk("func_pass", 64'(mem_addr_a), 64'h1F4);
    bist_en = 1'b1;

    // Out-of-range and spare errors
    err_pulse(9'h1F4);
    chk("oor_cnt",  64'(bist_repair_cnt), 64'd3);
    chk("oor_fail", 64'(bist_fail_repair), 64'd0);
    err_pulse(9'h1FA);
    chk("spare_fail", 64'(bist_fail_repair), 64'd1);
    chk("spare_corr", 64'(bist_correct), 64'd0);
    chk("spare_cnt",  64'(bist_repair_cnt), 64'd3);

    // Clear
    bist_repair_clr = 1'b1;
    tick();
    bist_repair_clr = 1'b0;
    chk("clr_cnt",  64'(bist_repair_cnt), 64'd0);
    chk("clr_fail", 64'(bist_fail_repair), 64'd0);

    // Overflow: five distinct errors
    for (int i = 0; i < 5; i++) err_pulse(9'h100 + 9'(i));
    chk("ovf_cnt",  64'(bist_repair_cnt), 64'd4);
    chk("ovf_fail", 64'(bist_fail_repair), 64'd1);
    chk("ovf_corr", 64'(bist_correct), 64'd0);
    bist_en     = 1'b0;
    func_addr_a = 9'h104;
    func_addr_b = 9'h103;
    #1;
    chk("ovf_pass", 64'(mem_addr_a), 64'h104);
    chk("ovf_last", 64'(mem_addr_b), 64'h1FB);
    bist_en = 1'b1;

    // Scan round trip: sdo looped to sdi for 40 bits
    exp_chain = {1'b1, 9'h103, 1'b1, 9'h102, 1'b1, 9'h101, 1'b1, 9'h100};
    stream    = '0;
    bist_shift = 1'b1;
    for (int k = 0; k < 40; k++) begin
      stream[k] = bist_sdo;
      bist_sdi  = bist_sdo;
      tick();
    end
    bist_shift = 1'b0;
    bist_sdi   = 1'b0;
    chk("scan_stream", 64'(stream), 64'(exp_chain));
    chk("scan_cnt", 64'(bist_repair_cnt), 64'd4);
    chk("scan_fail_kept", 64'(bist_fail_repair), 64'd1);
    bist_en     = 1'b0;
    func_addr_a = 9'h102;
    func_addr_b = 9'h100;
    #1;
    chk("scan_remap_a", 64'(mem_addr_a), 64'h1FA);
    chk("scan_remap_b", 64'(mem_addr_b), 64'h1F8);
    bist_en = 1'b1;

    // Shift 40 zeros empties the table
    bist_shift = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    bist_shift = 1'b0;
    chk("zero_cnt", 64'(bist_repair_cnt), 64'd0);
    chk("zero_sdo", 64'(bist_sdo), 64'd0);

    // Priority: error with shift and with clear are dropped
    bist_shift = 1'b1;
    err_pulse(9'h050);
    bist_shift = 1'b0;
    chk("prio_shift", 64'(bist_repair_cnt), 64'd0);
    bist_repair_clr = 1'b1;
    err_pulse(9'h060);
    bist_repair_clr = 1'b0;
    chk("prio_clr_cnt",  64'(bist_repair_cnt), 64'd0);
    chk("prio_clr_fail", 64'(bist_fail_repair), 64'd0);

    // Scan-mode read data mux
    bist_wdata = 32'hDEADBEEF;
    mem_dout_a = 32'h12345678;
    #1;
    chk("dout_func", 64'(func_dout_a), 64'h12345678);
    scan_mode = 1'b1;
    #1;
    chk("dout_scan", 64'(func_dout_a), 64'hDEADBEEF);
    scan_mode = 1'b0;

    // Asynchronous reset clears the table between edges
    err_pulse(9'h070);
    chk("pre_rst_cnt", 64'(bist_repair_cnt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 64'(bist_repair_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
